// File: rtl/pipe_ripple_adder_pkg.sv
// Shared helpers for the pipelined ripple adder: chunk sizing, shape check, stage control record.
// Consumed by pipe_ripple_stage and pipe_ripple_adder.
package pipe_ripple_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Bits handled by each pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // A legal shape has at least one stage and splits WIDTH into equal non-empty chunks.
  function automatic bit shape_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

  // Control half of a stage record; the data half (partial result, remaining operands)
  // depends on WIDTH and lives beside it in the stage.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_ripple_stage.sv
// One pipeline stage: adds chunk IDX of the operands plus the incoming carry and registers the record.
// With PIPE_RIPPLE_ADDER_OVF_EN defined, the last stage also registers signed overflow.
module pipe_ripple_stage
  import pipe_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_res,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic             dn_ready,
  output logic             dn_valid,
  output logic             dn_carry,
  output logic [WIDTH-1:0] dn_res,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b,
  output logic             dn_ovf
);

  localparam int CHUNK   = chunk_width(WIDTH, STAGES);
  localparam int LO      = IDX * CHUNK;
  localparam bit IS_LAST = (IDX == STAGES - 1);

  stage_ctrl_t      ctrl_reg, ctrl_next;
  logic [WIDTH-1:0] res_reg, a_reg, b_reg;
  logic [WIDTH-1:0] res_next;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             load;

  // Chunks at and above IDX are still zero in up_res, so OR-ing inserts this stage's chunk.
  always_comb begin
    {chunk_cout, chunk_sum} = {1'b0, up_a[LO +: CHUNK]} + {1'b0, up_b[LO +: CHUNK]}
                            + {{CHUNK{1'b0}}, up_carry};
    res_next = up_res | (WIDTH'(chunk_sum) << LO);
  end

  assign up_ready = ~ctrl_reg.valid | dn_ready;
  assign load     = up_valid & up_ready;

  always_comb begin
    ctrl_next = ctrl_reg;
    if (up_ready) begin
      ctrl_next.valid = up_valid;
    end
    if (load) begin
      ctrl_next.carry = chunk_cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg <= '0;
      res_reg  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
    end else begin
      ctrl_reg <= ctrl_next;
      if (load) begin
        res_reg <= res_next;
        a_reg   <= up_a;
        b_reg   <= up_b;
      end
    end
  end

  assign dn_valid = ctrl_reg.valid;
  assign dn_carry = ctrl_reg.carry;
  assign dn_res   = res_reg;
  assign dn_a     = a_reg;
  assign dn_b     = b_reg;

`ifdef PIPE_RIPPLE_ADDER_OVF_EN
  logic ovf_reg;
  if (IS_LAST) begin : g_ovf
    logic msb_cin;
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign msb_cin = up_a[WIDTH-1] ^ up_b[WIDTH-1] ^ chunk_sum[CHUNK-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ovf_reg <= 1'b0;
      end else if (load) begin
        ovf_reg <= msb_cin ^ chunk_cout;
      end
    end
  end else begin : g_no_ovf
    assign ovf_reg = 1'b0;
  end
  assign dn_ovf = ovf_reg;
`else
  assign dn_ovf = 1'b0;
`endif

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready on both sides, one chunk per stage.
// Optional macro PIPE_RIPPLE_ADDER_OVF_EN enables the signed overflow output; otherwise ovf is 0.
module pipe_ripple_adder
  import pipe_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  if (!shape_ok(WIDTH, STAGES)) begin : g_bad_shape
    $error("pipe_ripple_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic             v_w   [STAGES+1];
  logic             rdy_w [STAGES+1];
  logic             c_w   [STAGES+1];
  logic [WIDTH-1:0] res_w [STAGES+1];
  logic [WIDTH-1:0] a_w   [STAGES];
  logic [WIDTH-1:0] b_w   [STAGES];
  logic             ovf_last;

  // Subtraction is a + ~b + ~cin, so cin doubles as an active-high borrow-in.
  assign v_w[0]       = in_valid;
  assign in_ready     = rdy_w[0];
  assign c_w[0]       = cin ^ sub;
  assign res_w[0]     = '0;
  assign a_w[0]       = a;
  assign b_w[0]       = sub ? ~b : b;
  assign rdy_w[STAGES] = out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == STAGES - 1) begin : g_last
      pipe_ripple_stage #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .IDX   (gi)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .up_valid(v_w[gi]),
        .up_ready(rdy_w[gi]),
        .up_carry(c_w[gi]),
        .up_res  (res_w[gi]),
        .up_a    (a_w[gi]),
        .up_b    (b_w[gi]),
        .dn_ready(rdy_w[gi+1]),
        .dn_valid(v_w[gi+1]),
        .dn_carry(c_w[gi+1]),
        .dn_res  (res_w[gi+1]),
        .dn_a    (),
        .dn_b    (),
        .dn_ovf  (ovf_last)
      );
    end else begin : g_mid
      pipe_ripple_stage #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .IDX   (gi)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .up_valid(v_w[gi]),
        .up_ready(rdy_w[gi]),
        .up_carry(c_w[gi]),
        .up_res  (res_w[gi]),
        .up_a    (a_w[gi]),
        .up_b    (b_w[gi]),
        .dn_ready(rdy_w[gi+1]),
        .dn_valid(v_w[gi+1]),
        .dn_carry(c_w[gi+1]),
        .dn_res  (res_w[gi+1]),
        .dn_a    (a_w[gi+1]),
        .dn_b    (b_w[gi+1]),
        .dn_ovf  ()
      );
    end
  end

  assign out_valid = v_w[STAGES];
  assign sum       = res_w[STAGES];
  assign carry     = c_w[STAGES];
  assign ovf       = ovf_last;

endmodule
